fifo_threshold_monitor: RTL and testbench

- Upstream flow-control stage for the QoS FSM.
- Watches the occupancy count of each of the NUM_FIFOS virtual-channel FIFOs and compares it against configurable high and low watermarks, with hysteresis and a minimum hold time.
- Emits one-cycle pause_fifos / continue_fifos strobes per FIFO; these drive the QoS FSM's pause_fifos / continue_fifos inputs.
- Watermarks are loaded while set_init is high; the QoS FSM sits in its Init state during that time.

---
 rtl/fifo_threshold_monitor.sv | 102 ++++++++++
 tb/tb_fifo_threshold_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_threshold_monitor.sv
// Watermark monitor with hysteresis and hold time for the virtual-channel FIFOs.
// Ports: CLK, reset (sync, active-low), set_init, thr_high_in, thr_low_in,
//   occ (packed, CNT_W per FIFO); pause_fifos/continue_fifos strobes,
//   paused level and sticky cfg_err out.
module fifo_threshold_monitor #(
    parameter int NUM_FIFOS = 4,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       set_init,
    input  logic [CNT_W-1:0]           thr_high_in,
    input  logic [CNT_W-1:0]           thr_low_in,
    input  logic [NUM_FIFOS*CNT_W-1:0] occ,
    output logic [NUM_FIFOS-1:0]       pause_fifos,
    output logic [NUM_FIFOS-1:0]       continue_fifos,
    output logic [NUM_FIFOS-1:0]       paused,
    output logic                       cfg_err
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    logic [CNT_W-1:0]     thr_high;
    logic [CNT_W-1:0]     thr_low;
    logic [HW-1:0]        hold     [NUM_FIFOS];
    logic [HW-1:0]        nxt_hold [NUM_FIFOS];
    logic [CNT_W-1:0]     occ_ch   [NUM_FIFOS];
    logic [NUM_FIFOS-1:0] nxt_paused;
    logic [NUM_FIFOS-1:0] nxt_pause;
    logic [NUM_FIFOS-1:0] nxt_cont;
    logic                 cfg_ok;

    assign cfg_ok = (thr_low_in < thr_high_in) &&
                    (thr_high_in <= CNT_W'(DEPTH));

    always_comb begin
        for (int i = 0; i < NUM_FIFOS; i++) begin
            occ_ch[i] = occ[i*CNT_W +: CNT_W];
        end
    end

    // Per-channel next state; a transition is only allowed once the
    // hold counter has drained, which enforces the minimum dwell time.
    always_comb begin
        nxt_paused = paused;
        nxt_pause  = '0;
        nxt_cont   = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            nxt_hold[i] = (hold[i] != '0) ? hold[i] - HW'(1) : '0;
            if (hold[i] == '0) begin
                if (!paused[i] && occ_ch[i] >= thr_high) begin
                    nxt_paused[i] = 1'b1;
                    nxt_pause[i]  = 1'b1;
                    nxt_hold[i]   = HW'(HOLD_CYC);
                end else if (paused[i] && occ_ch[i] <= thr_low) begin
                    nxt_paused[i] = 1'b0;
                    nxt_cont[i]   = 1'b1;
                    nxt_hold[i]   = HW'(HOLD_CYC);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            thr_high       <= CNT_W'(DEPTH - 2);
            thr_low        <= CNT_W'(2);
            cfg_err        <= 1'b0;
            paused         <= '0;
            pause_fifos    <= '0;
            continue_fifos <= '0;
            for (int i = 0; i < NUM_FIFOS; i++) begin
                hold[i] <= '0;
            end
        end else if (set_init) begin
            if (cfg_ok) begin
                thr_high <= thr_high_in;
                thr_low  <= thr_low_in;
                cfg_err  <= 1'b0;
            end else begin
                cfg_err  <= 1'b1;
            end
            // Channels are silently returned to RUN; no continue strobe.
            paused         <= '0;
            pause_fifos    <= '0;
            continue_fifos <= '0;
            for (int i = 0; i < NUM_FIFOS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            paused         <= nxt_paused;
            pause_fifos    <= nxt_pause;
            continue_fifos <= nxt_cont;
            for (int i = 0; i < NUM_FIFOS; i++) begin
                hold[i] <= nxt_hold[i];
            end
        end
    end

endmodule

// File: tb/tb_fifo_threshold_monitor.sv
// Self-checking bench for fifo_threshold_monitor.
// Vector table plus hand-written sequences, checked through a queue.
module tb_fifo_threshold_monitor;

    logic        CLK;
    logic        reset;
    logic        set_init;
    logic [3:0]  thr_high_in;
    logic [3:0]  thr_low_in;
    logic [15:0] occ;
    logic [3:0]  pause_fifos;
    logic [3:0]  continue_fifos;
    logic [3:0]  paused;
    logic        cfg_err;

    typedef struct {
        logic        rst_n;
        logic        init;
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic [15:0] occ;
        logic [3:0]  p;
        logic [3:0]  c;
        logic [3:0]  pd;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = 0;

    fifo_threshold_monitor #(
        .NUM_FIFOS(4),
        .DEPTH(8),
        .CNT_W(4),
        .HOLD_CYC(2)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .set_init(set_init),
        .thr_high_in(thr_high_in),
        .thr_low_in(thr_low_in),
        .occ(occ),
        .pause_fifos(pause_fifos),
        .continue_fifos(continue_fifos),
        .paused(paused),
        .cfg_err(cfg_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic void add(input logic r, input logic in,
                                input logic [3:0] hi, input logic [3:0] lo,
                                input logic [15:0] o, input logic [3:0] p,
                                input logic [3:0] c, input logic [3:0] pd,
                                input logic e);
        vec_t v;
        v.rst_n = r;
        v.init  = in;
        v.hi    = hi;
        v.lo    = lo;
        v.occ   = o;
        v.p     = p;
        v.c     = c;
        v.pd    = pd;
        v.err   = e;
        tbl.push_back(v);
    endfunction

    task automatic chk4(input string nm, input logic [3:0] got,
                        input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL row%0d %s got %b want %b", row, nm, got, want);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        reset       = v.rst_n;
        set_init    = v.init;
        thr_high_in = v.hi;
        thr_low_in  = v.lo;
        occ         = v.occ;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk4("pause_fifos", pause_fifos, e.p);
        chk4("continue_fifos", continue_fifos, e.c);
        chk4("paused", paused, e.pd);
        chk4("cfg_err", {3'b0, cfg_err}, {3'b0, e.err});
        row++;
    endtask

    task automatic run(input logic [15:0] o, input logic [3:0] p,
                       input logic [3:0] c, input logic [3:0] pd);
        vec_t v;
        v.rst_n = 1'b1;
        v.init  = 1'b0;
        v.hi    = 4'd0;
        v.lo    = 4'd0;
        v.occ   = o;
        v.p     = p;
        v.c     = c;
        v.pd    = pd;
        v.err   = 1'b0;
        step(v);
    endtask

    initial begin
        // rst init hi lo occ p c pd err
        add(0, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0001, 4'b0000, 4'b0001, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0000, 4'b0000, 4'b0001, 0);
        add(1, 0, 0, 0, 16'h0066, 4'b0010, 4'b0000, 4'b0011, 0);
        add(1, 0, 0, 0, 16'h0056, 4'b0000, 4'b0000, 4'b0011, 0);
        add(1, 0, 0, 0, 16'h0046, 4'b0000, 4'b0000, 4'b0011, 0);
        add(1, 0, 0, 0, 16'h0036, 4'b0000, 4'b0000, 4'b0011, 0);
        add(1, 0, 0, 0, 16'h0026, 4'b0000, 4'b0010, 4'b0001, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0000, 4'b0000, 4'b0001, 0);
        add(1, 0, 0, 0, 16'h0606, 4'b0100, 4'b0000, 4'b0101, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0000, 4'b0000, 4'b0101, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0000, 4'b0000, 4'b0101, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0000, 4'b0100, 4'b0001, 0);
        add(1, 0, 0, 0, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 0);
        add(1, 0, 0, 0, 16'h0060, 4'b0010, 4'b0000, 4'b0010, 0);
        add(1, 0, 0, 0, 16'h0060, 4'b0000, 4'b0000, 4'b0010, 0);
        add(1, 0, 0, 0, 16'h0060, 4'b0000, 4'b0000, 4'b0010, 0);
        add(1, 0, 0, 0, 16'h0806, 4'b0101, 4'b0010, 4'b0101, 0);
        add(1, 1, 7, 1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 0, 0, 0, 16'h6000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 0, 0, 0, 16'h7000, 4'b1000, 4'b0000, 4'b1000, 0);
        add(1, 1, 3, 5, 16'h7000, 4'b0000, 4'b0000, 4'b0000, 1);
        add(1, 0, 0, 0, 16'h6000, 4'b0000, 4'b0000, 4'b0000, 1);
        add(1, 0, 0, 0, 16'h7000, 4'b1000, 4'b0000, 4'b1000, 1);
        add(1, 1, 9, 1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1);
        add(1, 1, 7, 1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 0, 0, 0, 16'h0007, 4'b0001, 4'b0000, 4'b0001, 0);
        add(0, 1, 3, 5, 16'h0007, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0001, 4'b0000, 4'b0001, 0);
        add(1, 0, 0, 0, 16'h0006, 4'b0000, 4'b0000, 4'b0001, 0);
        add(1, 0, 0, 0, 16'h00F6, 4'b0010, 4'b0000, 4'b0011, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Both channels paused; ch1 still holding while ch0 releases.
        run(16'h0000, 4'b0000, 4'b0001, 4'b0010);
        run(16'h0006, 4'b0000, 4'b0000, 4'b0010);
        run(16'h0006, 4'b0000, 4'b0010, 4'b0000);
        run(16'h0006, 4'b0001, 4'b0000, 4'b0001);

        // Fast oscillation on ch2: strobes spaced HOLD_CYC+1 apart.
        run(16'h0606, 4'b0100, 4'b0000, 4'b0101);
        run(16'h0006, 4'b0000, 4'b0000, 4'b0101);
        run(16'h0606, 4'b0000, 4'b0000, 4'b0101);
        run(16'h0006, 4'b0000, 4'b0100, 4'b0001);
        run(16'h0606, 4'b0000, 4'b0000, 4'b0001);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
